delay_96_cfg_ctrl: RTL and testbench
====================================

# delay_96_cfg_ctrl

Configuration sequencer for a bank of `delay_96` programmable delay lines. It buffers per-channel delay settings written over a simple command port. On an apply request it runs a fixed sequence: a common reset pulse, then one load strobe per channel, then a settle wait. It then re-enables downstream data. It sits between the control/register interface and the channel-alignment delay lines, and guarantees that all channels change delay together and that no data is consumed while the lines refill.

## Interface
Parameters:
- `N_CH`, 2: number of controlled `delay_96` instances, 1..16.
- `MAX_DLY`, 20: depth of the delay lines (`size` of `delay_96`). Legal delay codes are 0..MAX_DLY-1. This is also the settle wait length.

Ports:
- `clk` in 1: single clock. All logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: write of one channel's delay code.
- `cmd_ch` in 4: target channel index.
- `cmd_dly` in 8: requested delay code.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `apply` in 1: single-cycle request to push all shadow codes to the delay lines.
- `err_clr` in 1: clears `err`.
- `dl_rst` out 1: common reset to all delay lines.
- `dl_wr_comm` out N_CH: per-channel load strobe (`wr_comm`).
- `dl_upr` out 8*N_CH: per-channel delay code (`upr`). Channel k occupies bits [8k+7:8k].
- `busy` out 1: a sequence is in progress.
- `done` out 1: one-cycle pulse at the end of a sequence.
- `data_en` out 1: downstream may use delay-line outputs.
- `err` out 2: sticky error flags. Bit 0 = illegal command; bit 1 = apply lost.

## Operation
- Shadow registers `shd[k]` are 8 bits each and are written only in IDLE on an accepted command.
- A `cmd_dly` value ≥ MAX_DLY is clamped to MAX_DLY-1 and sets `err[0]`.
- A `cmd_ch` value ≥ N_CH is dropped (no shadow is written) and sets `err[0]`.
- `cmd_ready` = 1 only in IDLE. Commands are never accepted while `busy`.
- FSM states: IDLE → RST → LOAD(k), for k = 0..N_CH-1 → SETTLE → DONE → IDLE.
  - IDLE: leaves only on `apply` = 1.
  - RST: lasts one cycle. `dl_rst` = 1.
  - LOAD(k): lasts one cycle per channel. `dl_wr_comm[k]` = 1, and the `dl_upr` slice for channel k is loaded from `shd[k]`. This is a registered copy and holds after the strobe.
  - SETTLE: down-counter preset to MAX_DLY and decremented each cycle. Exits when the counter reaches 1.
  - DONE: lasts one cycle. `done` = 1.
- `data_en` is cleared on entry to RST. It is set on the DONE→IDLE transition and stays 1 in IDLE until the next apply.
- If `cmd_valid` and `apply` arrive in the same IDLE cycle, the command is written first and is included in that sequence (forwarding path into LOAD).
- `apply` while not in IDLE is ignored and sets `err[1]`. The running sequence is unaffected.
- `err` bits are sticky until `err_clr` or `rst`. If `err_clr` and a new error occur in the same cycle, the error wins.
- At most one `dl_wr_comm` bit is high in any cycle. `dl_rst` and `dl_wr_comm` are never high together.

## Timing
- Reset values (cycle after `rst` is sampled high):
  - state = IDLE
  - `shd` = 0 and `dl_upr` = 0
  - `dl_rst` = 0 and `dl_wr_comm` = 0
  - `busy` = 0, `done` = 0, `data_en` = 0
  - `err` = 0
  - `cmd_ready` = 1
- Reset mid-sequence aborts immediately and produces no `done`. `data_en` stays 0 until a full sequence completes.
- All outputs are registered.
- With `apply` sampled at edge E0:
  - `dl_rst` is high during E0–E1.
  - `dl_wr_comm[k]` is high during E(1+k)–E(2+k).
  - SETTLE spans E(1+N_CH) to E(1+N_CH+MAX_DLY).
  - `done` is high for one cycle after that.
  - `data_en` rises at E(2+N_CH+MAX_DLY).
- `busy` is high for exactly N_CH+MAX_DLY+2 cycles starting after E0. For the defaults this is 24 cycles.
- A command latency is one cycle: the shadow is updated at the edge after acceptance.

## Test plan
- Reset: hold `rst` for 10 cycles → all outputs at their reset values, `cmd_ready` = 1, `data_en` = 0.
- Write ch0 = 0 and ch1 = 1, then `apply` → `dl_rst` pulse for 1 cycle, `dl_wr_comm` = 01 then 10 on consecutive cycles, `dl_upr` = {8'd1, 8'd0}, `busy` high for 24 cycles, `done` pulses once, `data_en` = 1 afterwards.
- `cmd_valid` (ch1, 3) in the same cycle as `apply` → the sequence loads `dl_upr` ch1 = 3. Repeat with ch1 = 2 → ch1 = 2.
- `cmd_dly` = 25 on ch0 → shadow = 19 and `err[0]` = 1. `cmd_ch` = 5 → no shadow change and `err[0]` = 1. `err_clr` → `err` = 0.
- `apply` pulsed 5 cycles into a sequence → no restart, `busy` still ends after 24 cycles total, `err[1]` = 1. A command offered while busy is not accepted until IDLE.
- `rst` asserted during SETTLE → next cycle IDLE, `dl_upr` = 0, no `done`, `data_en` = 0. A subsequent `apply` completes normally.

Source files
------------

// File: rtl/delay_96_cfg_ctrl_if.sv
// Command/apply port and delay-line drive bundle for delay_96_cfg_ctrl.
// master = register/control side, slave = the sequencer.
interface delay_96_cfg_ctrl_if #(
    parameter int N_CH = 2
);
    logic                cmd_valid;
    logic [3:0]          cmd_ch;
    logic [7:0]          cmd_dly;
    logic                cmd_ready;
    logic                apply;
    logic                err_clr;
    logic                dl_rst;
    logic [N_CH-1:0]     dl_wr_comm;
    logic [8*N_CH-1:0]   dl_upr;
    logic                busy;
    logic                done;
    logic                data_en;
    logic [1:0]          err;

    modport master (
        output cmd_valid, cmd_ch, cmd_dly, apply, err_clr,
        input  cmd_ready, dl_rst, dl_wr_comm, dl_upr, busy, done, data_en, err
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_dly, apply, err_clr,
        output cmd_ready, dl_rst, dl_wr_comm, dl_upr, busy, done, data_en, err
    );
endinterface

// File: rtl/delay_96_cfg_ctrl.sv
// Buffers per-channel delay codes and pushes them to a bank of delay_96 lines
// as one reset / load / settle sequence, gating downstream data meanwhile.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | accepting commands, waiting for apply
// S_RST    | one-cycle common reset pulse to all delay lines
// S_LOAD   | one cycle per channel, strobe wr_comm[r_ch] with its code
// S_SETTLE | down-counter from MAX_DLY while the lines refill
// S_DONE   | one-cycle done pulse, data re-enabled on exit
module delay_96_cfg_ctrl #(
    parameter int N_CH    = 2,
    parameter int MAX_DLY = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    delay_96_cfg_ctrl_if.slave     cfg_if
);
    localparam int CW = $clog2(MAX_DLY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_LOAD,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_ch;
    logic [3:0]          w_ch_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;

    logic [7:0]          r_shd [N_CH];
    logic [8*N_CH-1:0]   r_upr;
    logic [N_CH-1:0]     r_wr_comm;
    logic                r_dl_rst;
    logic                r_busy;
    logic                r_done;
    logic                r_data_en;
    logic                r_cmd_ready;
    logic [1:0]          r_err;

    logic                w_cmd_acc;
    logic                w_ch_bad;
    logic                w_dly_bad;
    logic [7:0]          w_dly_clamped;
    logic                w_apply_lost;

    // r_cmd_ready mirrors r_state == S_IDLE, so shadows only change in IDLE
    assign w_cmd_acc     = cfg_if.cmd_valid && r_cmd_ready;
    assign w_ch_bad      = ({1'b0, cfg_if.cmd_ch} >= 5'(N_CH));
    assign w_dly_bad     = ({1'b0, cfg_if.cmd_dly} >= 9'(MAX_DLY));
    assign w_dly_clamped = w_dly_bad ? 8'(MAX_DLY - 1) : cfg_if.cmd_dly;
    assign w_apply_lost  = cfg_if.apply && (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (cfg_if.apply) begin
                    w_state_nxt = S_RST;
                end
            end
            S_RST: begin
                w_state_nxt = S_LOAD;
                w_ch_nxt    = 4'd0;
            end
            S_LOAD: begin
                if (r_ch == 4'(N_CH - 1)) begin
                    w_state_nxt = S_SETTLE;
                    w_cnt_nxt   = CW'(MAX_DLY);
                end else begin
                    w_ch_nxt = r_ch + 4'd1;
                end
            end
            S_SETTLE: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ch        <= 4'd0;
            r_cnt       <= '0;
            r_upr       <= '0;
            r_wr_comm   <= '0;
            r_dl_rst    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_data_en   <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_err       <= 2'b00;
            for (int k = 0; k < N_CH; k++) begin
                r_shd[k] <= 8'd0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_ch        <= w_ch_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dl_rst    <= (w_state_nxt == S_RST);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
            r_cmd_ready <= (w_state_nxt == S_IDLE);

            // Loads happen at least one edge after the shadow write, so a
            // command accepted together with apply lands in this sequence.
            for (int k = 0; k < N_CH; k++) begin
                r_wr_comm[k] <= (w_state_nxt == S_LOAD) && (w_ch_nxt == 4'(k));
                if ((w_state_nxt == S_LOAD) && (w_ch_nxt == 4'(k))) begin
                    r_upr[8*k +: 8] <= r_shd[k];
                end
                if (w_cmd_acc && !w_ch_bad && (cfg_if.cmd_ch == 4'(k))) begin
                    r_shd[k] <= w_dly_clamped;
                end
            end

            if ((r_state == S_DONE) && (w_state_nxt == S_IDLE)) begin
                r_data_en <= 1'b1;
            end else if (w_state_nxt == S_RST) begin
                r_data_en <= 1'b0;
            end

            // New errors override a simultaneous clear
            r_err <= (cfg_if.err_clr ? 2'b00 : r_err)
                   | {w_apply_lost, w_cmd_acc && (w_ch_bad || w_dly_bad)};
        end
    end

    assign cfg_if.cmd_ready  = r_cmd_ready;
    assign cfg_if.dl_rst     = r_dl_rst;
    assign cfg_if.dl_wr_comm = r_wr_comm;
    assign cfg_if.dl_upr     = r_upr;
    assign cfg_if.busy       = r_busy;
    assign cfg_if.done       = r_done;
    assign cfg_if.data_en    = r_data_en;
    assign cfg_if.err        = r_err;
endmodule

// File: tb/tb_delay_96_cfg_ctrl.sv
// Directed bench for delay_96_cfg_ctrl with default parameters (N_CH=2, MAX_DLY=20).
module tb_delay_96_cfg_ctrl;
    localparam int N_CH    = 2;
    localparam int MAX_DLY = 20;
    localparam int OBS     = 40;
    localparam int SEQ_LEN = 24;   // N_CH + MAX_DLY + 2

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    delay_96_cfg_ctrl_if #(.N_CH(N_CH)) cfg ();

    delay_96_cfg_ctrl #(.N_CH(N_CH), .MAX_DLY(MAX_DLY)) dut (
        .clk    (clk),
        .rst    (rst),
        .cfg_if (cfg)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic            obs_busy  [OBS];
    logic            obs_done  [OBS];
    logic            obs_rst   [OBS];
    logic            obs_den   [OBS];
    logic            obs_ready [OBS];
    logic [N_CH-1:0] obs_wr    [OBS];
    int busy_cnt, done_cnt, done_at, rst_cnt, den_at, overlap, acc_at;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cmd(input logic [3:0] ch, input logic [7:0] dly);
        cfg.cmd_valid = 1'b1;
        cfg.cmd_ch    = ch;
        cfg.cmd_dly   = dly;
        step();
        cfg.cmd_valid = 1'b0;
    endtask

    // Issues apply, then records OBS cycles; cycle c is the interval after edge E(c).
    // Optionally re-pulses apply in cycle extra_apply_at and offers a command from cmd_from.
    task automatic run_seq(input int extra_apply_at, input int cmd_from,
                           input logic [3:0] ch, input logic [7:0] dly);
        bit accepted;
        accepted  = 1'b0;
        acc_at    = -1;
        cfg.apply = 1'b1;
        step();
        cfg.apply     = 1'b0;
        cfg.cmd_valid = 1'b0;
        for (int c = 0; c < OBS; c++) begin
            obs_busy[c]  = cfg.busy;
            obs_done[c]  = cfg.done;
            obs_rst[c]   = cfg.dl_rst;
            obs_den[c]   = cfg.data_en;
            obs_ready[c] = cfg.cmd_ready;
            obs_wr[c]    = cfg.dl_wr_comm;
            cfg.cmd_valid = (cmd_from >= 0) && (c >= cmd_from) && !accepted;
            cfg.cmd_ch    = ch;
            cfg.cmd_dly   = dly;
            if (cfg.cmd_valid && cfg.cmd_ready) begin
                accepted = 1'b1;
                acc_at   = c;
            end
            cfg.apply = (c == extra_apply_at);
            step();
        end
        cfg.cmd_valid = 1'b0;
        cfg.apply     = 1'b0;
        busy_cnt = 0; done_cnt = 0; rst_cnt = 0; overlap = 0;
        done_at = -1; den_at = -1;
        for (int c = 0; c < OBS; c++) begin
            busy_cnt += int'(obs_busy[c]);
            done_cnt += int'(obs_done[c]);
            rst_cnt  += int'(obs_rst[c]);
            if (obs_done[c] && done_at < 0) done_at = c;
            if (obs_den[c] && den_at < 0) den_at = c;
            if ((obs_rst[c] && (obs_wr[c] != '0)) || ($countones(obs_wr[c]) > 1)) overlap++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (10) step();
        rst = 1'b0;
        n_checks++; if (cfg.dl_rst !== 1'b0) $display("FAIL reset_dl_rst: got %b expected 0", cfg.dl_rst); else n_pass++;
        n_checks++; if (cfg.dl_wr_comm !== 2'b00) $display("FAIL reset_wr_comm: got %b expected 00", cfg.dl_wr_comm); else n_pass++;
        n_checks++; if (cfg.dl_upr !== 16'h0000) $display("FAIL reset_dl_upr: got %h expected 0000", cfg.dl_upr); else n_pass++;
        n_checks++; if (cfg.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", cfg.busy); else n_pass++;
        n_checks++; if (cfg.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", cfg.done); else n_pass++;
        n_checks++; if (cfg.data_en !== 1'b0) $display("FAIL reset_data_en: got %b expected 0", cfg.data_en); else n_pass++;
        n_checks++; if (cfg.err !== 2'b00) $display("FAIL reset_err: got %b expected 00", cfg.err); else n_pass++;
        n_checks++; if (cfg.cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b expected 1", cfg.cmd_ready); else n_pass++;
    endtask

    task automatic test_basic_sequence();
        write_cmd(4'd0, 8'd0);
        write_cmd(4'd1, 8'd1);
        run_seq(-1, -1, 4'd0, 8'd0);
        n_checks++; if (obs_rst[0] !== 1'b1) $display("FAIL basic_rst_at0: got %b expected 1", obs_rst[0]); else n_pass++;
        n_checks++; if (rst_cnt !== 1) $display("FAIL basic_rst_len: got %0d expected 1", rst_cnt); else n_pass++;
        n_checks++; if (obs_wr[1] !== 2'b01) $display("FAIL basic_wr_c1: got %b expected 01", obs_wr[1]); else n_pass++;
        n_checks++; if (obs_wr[2] !== 2'b10) $display("FAIL basic_wr_c2: got %b expected 10", obs_wr[2]); else n_pass++;
        n_checks++; if (obs_wr[3] !== 2'b00) $display("FAIL basic_wr_c3: got %b expected 00", obs_wr[3]); else n_pass++;
        n_checks++; if (overlap !== 0) $display("FAIL basic_strobe_overlap: got %0d expected 0", overlap); else n_pass++;
        n_checks++; if (busy_cnt !== SEQ_LEN) $display("FAIL basic_busy_len: got %0d expected %0d", busy_cnt, SEQ_LEN); else n_pass++;
        n_checks++; if (obs_busy[23] !== 1'b1 || obs_busy[24] !== 1'b0) $display("FAIL basic_busy_edge: got %b%b expected 10", obs_busy[23], obs_busy[24]); else n_pass++;
        n_checks++; if (done_cnt !== 1) $display("FAIL basic_done_count: got %0d expected 1", done_cnt); else n_pass++;
        n_checks++; if (done_at !== 23) $display("FAIL basic_done_at: got %0d expected 23", done_at); else n_pass++;
        n_checks++; if (den_at !== 24) $display("FAIL basic_data_en_at: got %0d expected 24", den_at); else n_pass++;
        n_checks++; if (obs_ready[0] !== 1'b0) $display("FAIL basic_ready_busy: got %b expected 0", obs_ready[0]); else n_pass++;
        n_checks++; if (cfg.dl_upr !== 16'h0100) $display("FAIL basic_dl_upr: got %h expected 0100", cfg.dl_upr); else n_pass++;
    endtask

    task automatic test_forwarding();
        cfg.cmd_valid = 1'b1; cfg.cmd_ch = 4'd1; cfg.cmd_dly = 8'd3;
        run_seq(-1, -1, 4'd0, 8'd0);
        n_checks++; if (cfg.dl_upr !== 16'h0300) $display("FAIL fwd_ch1_3: got %h expected 0300", cfg.dl_upr); else n_pass++;
        cfg.cmd_valid = 1'b1; cfg.cmd_ch = 4'd1; cfg.cmd_dly = 8'd2;
        run_seq(-1, -1, 4'd0, 8'd0);
        n_checks++; if (cfg.dl_upr !== 16'h0200) $display("FAIL fwd_ch1_2: got %h expected 0200", cfg.dl_upr); else n_pass++;
        n_checks++; if (done_cnt !== 1) $display("FAIL fwd_done_count: got %0d expected 1", done_cnt); else n_pass++;
    endtask

    task automatic test_errors();
        write_cmd(4'd0, 8'd25);
        n_checks++; if (cfg.err !== 2'b01) $display("FAIL err_clamp_flag: got %b expected 01", cfg.err); else n_pass++;
        cfg.err_clr = 1'b1; step(); cfg.err_clr = 1'b0;
        n_checks++; if (cfg.err !== 2'b00) $display("FAIL err_clear: got %b expected 00", cfg.err); else n_pass++;
        write_cmd(4'd5, 8'd4);
        n_checks++; if (cfg.err !== 2'b01) $display("FAIL err_bad_ch: got %b expected 01", cfg.err); else n_pass++;
        cfg.err_clr = 1'b1;
        write_cmd(4'd0, 8'd30);
        cfg.err_clr = 1'b0;
        n_checks++; if (cfg.err !== 2'b01) $display("FAIL err_wins_over_clr: got %b expected 01", cfg.err); else n_pass++;
        cfg.err_clr = 1'b1; step(); cfg.err_clr = 1'b0;
        run_seq(-1, -1, 4'd0, 8'd0);
        n_checks++; if (cfg.dl_upr !== 16'h0213) $display("FAIL err_clamped_load: got %h expected 0213", cfg.dl_upr); else n_pass++;
        n_checks++; if (cfg.err !== 2'b00) $display("FAIL err_after_seq: got %b expected 00", cfg.err); else n_pass++;
    endtask

    task automatic test_apply_while_busy();
        run_seq(4, 5, 4'd0, 8'd7);
        n_checks++; if (busy_cnt !== SEQ_LEN) $display("FAIL busy_apply_len: got %0d expected %0d", busy_cnt, SEQ_LEN); else n_pass++;
        n_checks++; if (rst_cnt !== 1) $display("FAIL busy_apply_restart: got %0d expected 1", rst_cnt); else n_pass++;
        n_checks++; if (done_at !== 23) $display("FAIL busy_apply_done_at: got %0d expected 23", done_at); else n_pass++;
        n_checks++; if (obs_ready[5] !== 1'b0) $display("FAIL busy_cmd_ready: got %b expected 0", obs_ready[5]); else n_pass++;
        n_checks++; if (acc_at !== 24) $display("FAIL busy_cmd_accept_at: got %0d expected 24", acc_at); else n_pass++;
        n_checks++; if (cfg.err !== 2'b10) $display("FAIL busy_apply_lost: got %b expected 10", cfg.err); else n_pass++;
        run_seq(-1, -1, 4'd0, 8'd0);
        n_checks++; if (cfg.dl_upr !== 16'h0207) $display("FAIL busy_cmd_loaded: got %h expected 0207", cfg.dl_upr); else n_pass++;
    endtask

    task automatic test_reset_mid_sequence();
        int dones;
        cfg.apply = 1'b1; step(); cfg.apply = 1'b0;
        repeat (9) step();
        rst = 1'b1; step(); rst = 1'b0;
        n_checks++; if (cfg.busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", cfg.busy); else n_pass++;
        n_checks++; if (cfg.dl_upr !== 16'h0000) $display("FAIL midrst_dl_upr: got %h expected 0000", cfg.dl_upr); else n_pass++;
        n_checks++; if (cfg.data_en !== 1'b0) $display("FAIL midrst_data_en: got %b expected 0", cfg.data_en); else n_pass++;
        n_checks++; if (cfg.cmd_ready !== 1'b1) $display("FAIL midrst_cmd_ready: got %b expected 1", cfg.cmd_ready); else n_pass++;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            dones += int'(cfg.done);
            step();
        end
        n_checks++; if (dones !== 0) $display("FAIL midrst_no_done: got %0d expected 0", dones); else n_pass++;
        n_checks++; if (cfg.data_en !== 1'b0) $display("FAIL midrst_data_en_held: got %b expected 0", cfg.data_en); else n_pass++;
        write_cmd(4'd0, 8'd4);
        write_cmd(4'd1, 8'd9);
        run_seq(-1, -1, 4'd0, 8'd0);
        n_checks++; if (cfg.dl_upr !== 16'h0904) $display("FAIL midrst_reapply_upr: got %h expected 0904", cfg.dl_upr); else n_pass++;
        n_checks++; if (done_cnt !== 1) $display("FAIL midrst_reapply_done: got %0d expected 1", done_cnt); else n_pass++;
        n_checks++; if (den_at !== 24) $display("FAIL midrst_reapply_data_en: got %0d expected 24", den_at); else n_pass++;
    endtask

    initial begin
        cfg.cmd_valid = 1'b0;
        cfg.cmd_ch    = 4'd0;
        cfg.cmd_dly   = 8'd0;
        cfg.apply     = 1'b0;
        cfg.err_clr   = 1'b0;
        test_reset();
        test_basic_sequence();
        test_forwarding();
        test_errors();
        test_apply_while_busy();
        test_reset_mid_sequence();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
